// File: rtl/lpt_update_sched.sv
// Shares the single LPT address port between fetch lookups and buffered
// branch-resolution updates. Lookups win unless an update must be forced.
module lpt_update_sched #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lkp_valid,
    input  logic [ADDR_W-1:0] lkp_addr,
    output logic              lkp_stall,
    output logic              pred_valid,
    output logic              pred_out,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic              res_taken,
    output logic              res_ready,
    input  logic              drain_req,
    output logic              drain_done,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic              tbl_upd,
    output logic              tbl_result,
    input  logic              tbl_pred
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(STARVE_LIM + 1);

    typedef enum logic {StNormal, StDrain} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  mem_addr_q [DEPTH];
    logic [ADDR_W-1:0]  mem_addr_d [DEPTH];
    logic               mem_taken_q [DEPTH];
    logic               mem_taken_d [DEPTH];

    logic hazard;
    logic force_upd;
    logic push;
    logic pop;
    logic drain_last;
    logic [PTR_W-1:0] slot_off;

    // Lookup hazard: the requested index matches any occupied FIFO slot.
    always_comb begin
        hazard   = 1'b0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - head_q;
            if (lkp_valid && (mem_addr_q[i] == lkp_addr) && (CNT_W'(slot_off) < count_q)) begin
                hazard = 1'b1;
            end
        end
    end

    // Port grant and lookup-side outputs.
    always_comb begin
        // flush_q keeps updates flowing after a full FIFO so the stall stays DEPTH cycles.
        force_upd  = (count_q != '0) &&
                     ((state_q == StDrain) || (count_q == CNT_W'(DEPTH)) ||
                      (age_q >= AGE_W'(STARVE_LIM)) || (flush_q != '0) || hazard);
        tbl_upd    = force_upd || ((count_q != '0) && !lkp_valid);
        tbl_addr   = tbl_upd ? mem_addr_q[head_q] : lkp_addr;
        tbl_result = tbl_upd ? mem_taken_q[head_q] : 1'b0;
        pred_valid = lkp_valid && !tbl_upd;
        pred_out   = pred_valid ? tbl_pred : 1'b0;
        lkp_stall  = lkp_valid && tbl_upd;
        res_ready  = (count_q < CNT_W'(DEPTH)) && (state_q == StNormal);
        push       = res_valid && res_ready;
        pop        = tbl_upd;
        drain_last = (state_q == StDrain) && pop && (count_q == CNT_W'(1));
        drain_done = done_q || drain_last;
    end

    // FIFO pointers, occupancy, head age and full-flush countdown.
    always_comb begin
        head_d      = pop ? head_q + PTR_W'(1) : head_q;
        tail_d      = push ? tail_q + PTR_W'(1) : tail_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        mem_addr_d  = mem_addr_q;
        mem_taken_d = mem_taken_q;
        if (push) begin
            mem_addr_d[tail_q]  = res_addr;
            mem_taken_d[tail_q] = res_taken;
        end
        age_d = age_q;
        if (pop || (count_q == '0)) begin
            age_d = '0;
        end else if (age_q < AGE_W'(STARVE_LIM)) begin
            age_d = age_q + AGE_W'(1);
        end
        flush_d = flush_q;
        if (pop && (count_q == CNT_W'(DEPTH))) begin
            flush_d = CNT_W'(DEPTH - 1);
        end else if (pop && (flush_q != '0)) begin
            flush_d = flush_q - CNT_W'(1);
        end
        if (count_d == '0) begin
            flush_d = '0;
        end
    end

    // Drain state machine; an empty drain completes on the following cycle.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (drain_req) begin
                    if (count_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_last) begin
                    state_d = StNormal;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StNormal;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
            flush_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    // FIFO payload storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        mem_addr_q  <= mem_addr_d;
        mem_taken_q <= mem_taken_d;
    end

endmodule

// File: tb/tb_lpt_update_sched.sv
module tb_lpt_update_sched;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [4:0] la;
        logic       rv;
        logic [4:0] ra;
        logic       rt;
        logic       dr;
        logic       tp;
        logic       e_stall;
        logic       e_pv;
        logic       e_po;
        logic       e_rr;
        logic [4:0] e_ta;
        logic       e_upd;
        logic       e_res;
        logic       e_dd;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       lkp_valid;
    logic [4:0] lkp_addr;
    logic       lkp_stall;
    logic       pred_valid;
    logic       pred_out;
    logic       res_valid;
    logic [4:0] res_addr;
    logic       res_taken;
    logic       res_ready;
    logic       drain_req;
    logic       drain_done;
    logic [4:0] tbl_addr;
    logic       tbl_upd;
    logic       tbl_result;
    logic       tbl_pred;

    int n_cmp;
    int n_fail;
    int step;

    lpt_update_sched #(
        .DEPTH     (4),
        .ADDR_W    (5),
        .STARVE_LIM(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lkp_valid (lkp_valid),
        .lkp_addr  (lkp_addr),
        .lkp_stall (lkp_stall),
        .pred_valid(pred_valid),
        .pred_out  (pred_out),
        .res_valid (res_valid),
        .res_addr  (res_addr),
        .res_taken (res_taken),
        .res_ready (res_ready),
        .drain_req (drain_req),
        .drain_done(drain_done),
        .tbl_addr  (tbl_addr),
        .tbl_upd   (tbl_upd),
        .tbl_result(tbl_result),
        .tbl_pred  (tbl_pred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, step, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic apply(input vec_t v, input bit do_chk);
        @(posedge clk);
        #1;
        rst       = v.rst;
        lkp_valid = v.lv;
        lkp_addr  = v.la;
        res_valid = v.rv;
        res_addr  = v.ra;
        res_taken = v.rt;
        drain_req = v.dr;
        tbl_pred  = v.tp;
        @(negedge clk);
        if (do_chk) begin
            chk("lkp_stall", {4'd0, lkp_stall}, {4'd0, v.e_stall});
            chk("pred_valid", {4'd0, pred_valid}, {4'd0, v.e_pv});
            chk("pred_out", {4'd0, pred_out}, {4'd0, v.e_po});
            chk("res_ready", {4'd0, res_ready}, {4'd0, v.e_rr});
            chk("tbl_addr", tbl_addr, v.e_ta);
            chk("tbl_upd", {4'd0, tbl_upd}, {4'd0, v.e_upd});
            chk("tbl_result", {4'd0, tbl_result}, {4'd0, v.e_res});
            chk("drain_done", {4'd0, drain_done}, {4'd0, v.e_dd});
        end
        step++;
    endtask

    // Lookups on addr 30 while three resolutions are queued, then a drain pulse.
    task automatic fill_and_drain();
        apply(vec_t'{0, 1, 30, 1, 5, 1, 0, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 1, 6, 0, 0, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 1, 7, 1, 0, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 1, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  1, 0, 0, 0,  5, 1, 1, 0}, 1'b1);
    endtask

    initial begin
        vec_t tbl[$];
        n_cmp  = 0;
        n_fail = 0;
        step   = 0;
        rst = 1'b1; lkp_valid = 1'b0; lkp_addr = '0; res_valid = 1'b0;
        res_addr = '0; res_taken = 1'b0; drain_req = 1'b0; tbl_pred = 1'b0;

        // rst, lv, la, rv, ra, rt, dr, tp | stall, pv, po, rr, ta, upd, res, dd
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0}); // reset state
        tbl.push_back(vec_t'{0, 1,  7, 0,  0, 0, 0, 1,  0, 1, 1, 1,  7, 0, 0, 0}); // idle lookup
        tbl.push_back(vec_t'{0, 0,  0, 1,  3, 1, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0}); // push {3,1}
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  3, 1, 1, 0}); // background write
        tbl.push_back(vec_t'{0, 0,  5, 0,  0, 0, 0, 0,  0, 0, 0, 1,  5, 0, 0, 0}); // empty again
        tbl.push_back(vec_t'{0, 1,  9, 1,  1, 0, 0, 1,  0, 1, 1, 1,  9, 0, 0, 0}); // fill 1
        tbl.push_back(vec_t'{0, 1,  9, 1,  2, 1, 0, 1,  0, 1, 1, 1,  9, 0, 0, 0}); // fill 2
        tbl.push_back(vec_t'{0, 1,  9, 1,  3, 0, 0, 1,  0, 1, 1, 1,  9, 0, 0, 0}); // fill 3
        tbl.push_back(vec_t'{0, 1,  9, 1,  4, 1, 0, 1,  0, 1, 1, 1,  9, 0, 0, 0}); // fill 4
        tbl.push_back(vec_t'{0, 1,  9, 0,  0, 0, 0, 1,  1, 0, 0, 0,  1, 1, 0, 0}); // full: forced
        tbl.push_back(vec_t'{0, 1,  9, 0,  0, 0, 0, 1,  1, 0, 0, 1,  2, 1, 1, 0});
        tbl.push_back(vec_t'{0, 1,  9, 0,  0, 0, 0, 1,  1, 0, 0, 1,  3, 1, 0, 0});
        tbl.push_back(vec_t'{0, 1,  9, 0,  0, 0, 0, 1,  1, 0, 0, 1,  4, 1, 1, 0});
        tbl.push_back(vec_t'{0, 1,  9, 0,  0, 0, 0, 1,  0, 1, 1, 1,  9, 0, 0, 0}); // served
        tbl.push_back(vec_t'{0, 0,  0, 1, 12, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0}); // push {12,0}
        tbl.push_back(vec_t'{0, 1, 12, 0,  0, 0, 0, 1,  1, 0, 0, 1, 12, 1, 0, 0}); // hazard stall
        tbl.push_back(vec_t'{0, 1, 12, 0,  0, 0, 0, 1,  0, 1, 1, 1, 12, 0, 0, 0}); // then served
        tbl.push_back(vec_t'{0, 0,  0, 1, 12, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0}); // push {12,0}
        tbl.push_back(vec_t'{0, 1, 13, 0,  0, 0, 0, 1,  0, 1, 1, 1, 13, 0, 0, 0}); // no hazard
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 12, 1, 0, 0}); // bg write
        tbl.push_back(vec_t'{0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0}); // empty

        apply(vec_t'{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0}, 1'b0);
        apply(vec_t'{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0}, 1'b0);
        foreach (tbl[i]) apply(tbl[i], 1'b1);

        // Starvation: entry {20,1} waits behind lookups of addr 21 until age hits 8.
        apply(vec_t'{0, 1, 21, 1, 20, 1, 0, 1,  0, 1, 1, 1, 21, 0, 0, 0}, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            apply(vec_t'{0, 1, 21, 0, 0, 0, 0, 1,  0, 1, 1, 1, 21, 0, 0, 0}, 1'b1);
        end
        apply(vec_t'{0, 1, 21, 0, 0, 0, 0, 1,  1, 0, 0, 1, 20, 1, 1, 0}, 1'b1);
        apply(vec_t'{0, 1, 21, 0, 0, 0, 0, 1,  0, 1, 1, 1, 21, 0, 0, 0}, 1'b1);

        // Full drain of three entries.
        fill_and_drain();
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  1, 0, 0, 0,  6, 1, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  1, 0, 0, 0,  7, 1, 1, 1}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        // Drain of an empty FIFO completes one cycle later.
        apply(vec_t'{0, 1, 30, 0, 0, 0, 1, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  0, 1, 0, 1, 30, 0, 0, 1}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);

        // Drain interrupted by rst during the second update.
        fill_and_drain();
        apply(vec_t'{1, 1, 30, 0, 0, 0, 0, 0,  1, 0, 0, 0,  6, 1, 0, 0}, 1'b1);
        apply(vec_t'{0, 1, 30, 0, 0, 0, 0, 0,  0, 1, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 0, 30, 0, 0, 0, 0, 0,  0, 0, 0, 1, 30, 0, 0, 0}, 1'b1);
        apply(vec_t'{0, 0, 30, 0, 0, 0, 0, 0,  0, 0, 0, 1, 30, 0, 0, 0}, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lpt_update_sched.md
# lpt_update_sched

Scheduler that shares the single address port of the 32-entry local prediction table (LPT) between two requesters: fetch-stage prediction lookups and execute-stage branch-resolution updates. Resolutions are buffered in a small FIFO and written back when the port is free. Lookups have priority, except that updates are forced through when the FIFO is full, when the head entry has aged out, when a lookup would read a stale entry, or when a drain is requested. The block sits between the fetch/execute stages and the LPT.

## Interface
- DEPTH, 4: resolution FIFO entries (power of two, ≥2)
- ADDR_W, 5: LPT index width
- STARVE_LIM, 8: head-entry age (cycles) that forces update priority

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- lkp_valid  in  1  fetch requests a prediction this cycle
- lkp_addr  in  ADDR_W  LPT index for the lookup
- lkp_stall  out  1  lookup not served this cycle; fetch holds lkp_addr
- pred_valid  out  1  pred_out is valid for lkp_addr this cycle
- pred_out  out  1  prediction (1 = taken)
- res_valid  in  1  branch resolved
- res_addr  in  ADDR_W  LPT index of the resolved branch
- res_taken  in  1  actual outcome
- res_ready  out  1  FIFO can accept; push = res_valid & res_ready
- drain_req  in  1  single-cycle pulse: flush all pending updates to the LPT
- drain_done  out  1  one-cycle pulse when the drain completes
- tbl_addr  out  ADDR_W  to LPT lpt_addr
- tbl_upd  out  1  to LPT upd_pred_state
- tbl_result  out  1  to LPT actual_brch_result
- tbl_pred  in  1  from LPT prediction (combinational read of tbl_addr)

## Operation
- FIFO holds {addr, taken}. Head/tail pointers and count are registered. count ranges 0..DEPTH.
- **States:**
  - NORMAL: reset state.
  - DRAIN: entered on drain_req. If drain_req arrives with count==0, stay in NORMAL and pulse drain_done the next cycle.
  - In DRAIN, res_ready=0 and an update is issued every cycle.
  - DRAIN exits to NORMAL on the cycle a pop makes count 0; drain_done pulses that same cycle.
  - drain_req while already in DRAIN is ignored.
- **force_upd** (combinational) = count>0 and any of:
  - state==DRAIN
  - count==DEPTH
  - age>=STARVE_LIM
  - lkp_valid and lkp_addr matches any valid FIFO entry (hazard)
- **Port grant, per cycle:**
  - If force_upd, or (count>0 and !lkp_valid): issue update. tbl_addr=head.addr, tbl_upd=1, tbl_result=head.taken, pop head.
  - Otherwise tbl_addr=lkp_addr and tbl_upd=0.
- **Lookup outputs:**
  - pred_valid = lkp_valid & !tbl_upd.
  - pred_out = tbl_pred when pred_valid, else 0.
  - lkp_stall = lkp_valid & tbl_upd.
- **Push/pop:**
  - res_ready = (count<DEPTH) & (state==NORMAL). There is no pass-through when full.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- **age:**
  - Counts cycles the current head has been waiting without being popped.
  - Clears on pop or when count==0. Saturates at STARVE_LIM.
- **Hazard rule:** an address with a pending update is never predicted from the stale LPT value. The lookup stalls until every matching entry has drained.

## Timing
- **Reset values:** res_ready=1, lkp_stall=0, pred_valid=0, pred_out=0, tbl_upd=0, tbl_result=0, drain_done=0, tbl_addr=lkp_addr, count=0, age=0, state NORMAL.
- **Lookup latency:** 0 cycles. The prediction is combinational in the request cycle.
- **Pushed entry:**
  - Visible to the grant and hazard logic from the next cycle.
  - Earliest LPT write is 1 cycle after the push; the write takes effect at the end of that issue cycle.
- **Worst-case lookup stall:**
  - No hazard: DEPTH cycles after the force condition.
  - Hazard: up to DEPTH cycles, bounded by the matching entry's FIFO position.
- rst asserted mid-operation (including mid-DRAIN) discards all FIFO contents. Outputs take reset values on the next edge. No LPT write is issued in the cycle after rst.

## Test plan
- **Idle lookup:** FIFO empty, lkp_valid=1, lkp_addr=7, tbl_pred=1 → tbl_addr=7, pred_valid=1, pred_out=1, lkp_stall=0, tbl_upd=0.
- **Background write:** push {3,1} with lkp_valid=0 next cycle → that cycle tbl_upd=1, tbl_addr=3, tbl_result=1; count returns to 0.
- **Full forcing:** lkp_valid held 1 on addr 9, then push 4 entries to addrs 1,2,3,4 → res_ready=0 at count 4. The next 4 cycles issue updates 1,2,3,4 in order with lkp_stall=1. Then pred_valid=1 on addr 9.
- **Hazard:** push {12,0}, then lookup addr 12 → lkp_stall=1 for one cycle while 12 is written, pred_valid=1 the following cycle. A lookup of addr 13 in the same scenario is served with no stall.
- **Starvation:** push one entry, hold lkp_valid=1 on a non-matching addr → the update is issued on the cycle age reaches 8 (STARVE_LIM), one-cycle stall.
- **Drain and reset:** push 3 entries, pulse drain_req → 3 consecutive updates, res_ready=0 throughout, drain_done pulses with the third. Repeat with rst at the second update → count=0, tbl_upd=0 next cycle, no further writes.
